// File: rtl/pcgen_pkg.sv
// pcgen_pkg: shared types and helpers for the fetch PC generator.
package pcgen_pkg;

    localparam int PC_W = 32;

    typedef enum logic [2:0] {
        RD_NONE,
        RD_REPLAY,
        RD_BR,
        RD_EXC,
        RD_ERET
    } redirect_kind_t;

    typedef enum logic {
        IDLE,
        REQ
    } pcgen_state_t;

    // Commit-time redirects are architectural and must never be overridden by speculative ones.
    function automatic logic is_commit_kind(input redirect_kind_t kind);
        return (kind == RD_EXC) || (kind == RD_ERET);
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch request channel from the PC generator (master) to I-fetch (slave).
interface pc_gen_if
    import pcgen_pkg::*;
#(
    parameter int FETCH_WIDTH = 2
) ();

    logic                   valid;
    logic                   ready;
    logic [PC_W-1:0]        pc;
    logic [FETCH_WIDTH-1:0] mask;
    logic                   addr_err;
    logic                   drop;

    modport master (
        output valid, pc, mask, addr_err, drop,
        input  ready
    );

    modport slave (
        input  valid, pc, mask, addr_err, drop,
        output ready
    );

endinterface

// File: rtl/pc_redirect_arb.sv
// pc_redirect_arb: picks the winning redirect this cycle and merges it with the buffered one.
module pc_redirect_arb
    import pcgen_pkg::*;
(
    input  logic            eret_valid,
    input  logic [PC_W-1:0] epc,
    input  logic            exc_valid,
    input  logic [PC_W-1:0] exc_entry,
    input  logic            br_valid,
    input  logic [PC_W-1:0] br_target,
    input  logic            replay_valid,
    input  logic [PC_W-1:0] replay_pc,
    input  redirect_kind_t  pend_kind,
    input  logic [PC_W-1:0] pend_pc,
    output logic            new_valid,
    output redirect_kind_t  merged_kind,
    output logic [PC_W-1:0] merged_pc
);

    redirect_kind_t  new_kind;
    logic [PC_W-1:0] new_pc;
    logic            take_new;

    always_comb begin
        new_kind = RD_NONE;
        new_pc   = '0;
        if (eret_valid) begin
            new_kind = RD_ERET;
            new_pc   = epc;
        end else if (exc_valid) begin
            new_kind = RD_EXC;
            new_pc   = exc_entry;
        end else if (br_valid) begin
            new_kind = RD_BR;
            new_pc   = br_target;
        end else if (replay_valid) begin
            new_kind = RD_REPLAY;
            new_pc   = replay_pc;
        end
    end

    assign new_valid = (new_kind != RD_NONE);

    // A speculative redirect may not displace a buffered commit-time one.
    always_comb begin
        take_new    = new_valid && (is_commit_kind(new_kind) || !is_commit_kind(pend_kind));
        merged_kind = take_new ? new_kind : pend_kind;
        merged_pc   = take_new ? new_pc   : pend_pc;
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: registered next-PC generator presenting fetch bundles over a valid/ready channel.
// Build option: define PCGEN_PRED_EN to honour pred_valid/pred_target at fire.
module pc_gen
    import pcgen_pkg::*;
#(
    parameter int              FETCH_WIDTH = 2,
    parameter logic [PC_W-1:0] RESET_PC    = 32'hbfc0_0000
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            eret_valid,
    input  logic [PC_W-1:0] epc,
    input  logic            exc_valid,
    input  logic [PC_W-1:0] exc_entry,
    input  logic            br_valid,
    input  logic [PC_W-1:0] br_target,
    input  logic            replay_valid,
    input  logic [PC_W-1:0] replay_pc,
    input  logic            pred_valid,
    input  logic [PC_W-1:0] pred_target,
    pc_gen_if.master        fetch
);

    localparam logic [PC_W-1:0] BUNDLE_BYTES = PC_W'(4 * FETCH_WIDTH);
    localparam logic [PC_W-1:0] BUNDLE_MASK  = BUNDLE_BYTES - PC_W'(1);

    pcgen_state_t    state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] pend_pc_q, pend_pc_d;
    redirect_kind_t  pend_kind_q, pend_kind_d;
    redirect_kind_t  merged_kind;
    logic [PC_W-1:0] merged_pc;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] slot_off;
    logic            new_valid;
    logic            fire;

    pc_redirect_arb u_arb (
        .eret_valid   (eret_valid),
        .epc          (epc),
        .exc_valid    (exc_valid),
        .exc_entry    (exc_entry),
        .br_valid     (br_valid),
        .br_target    (br_target),
        .replay_valid (replay_valid),
        .replay_pc    (replay_pc),
        .pend_kind    (pend_kind_q),
        .pend_pc      (pend_pc_q),
        .new_valid    (new_valid),
        .merged_kind  (merged_kind),
        .merged_pc    (merged_pc)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ:  state_d = REQ;
        endcase
    end

    assign fire   = (state_q == REQ) && fetch.ready;
    assign seq_pc = (fetch_pc_q & ~BUNDLE_MASK) + BUNDLE_BYTES;

    // Stalled redirects wait in the pending buffer; at fire the merged redirect wins over prediction.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        pend_kind_d = pend_kind_q;
        pend_pc_d   = pend_pc_q;
        if (state_q == IDLE) begin
            if (new_valid) begin
                fetch_pc_d = merged_pc;
            end
        end else if (fire) begin
            pend_kind_d = RD_NONE;
            if (merged_kind != RD_NONE) begin
                fetch_pc_d = merged_pc;
            end
`ifdef PCGEN_PRED_EN
            else if (pred_valid) begin
                fetch_pc_d = pred_target;
            end
`endif
            else begin
                fetch_pc_d = seq_pc;
            end
        end else if (new_valid) begin
            pend_kind_d = merged_kind;
            pend_pc_d   = merged_pc;
        end
    end

`ifndef PCGEN_PRED_EN
    logic unused_pred;
    assign unused_pred = pred_valid ^ (^pred_target);
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_pc_q  <= RESET_PC;
            pend_kind_q <= RD_NONE;
            pend_pc_q   <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            pend_kind_q <= pend_kind_d;
            pend_pc_q   <= pend_pc_d;
        end
    end

    assign slot_off = (fetch_pc_q & BUNDLE_MASK) >> 2;

    always_comb begin
        fetch.valid    = (state_q == REQ);
        fetch.pc       = fetch_pc_q;
        fetch.addr_err = |fetch_pc_q[1:0];
        fetch.drop     = (state_q == REQ) && ((pend_kind_q != RD_NONE) || new_valid);
        fetch.mask     = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            fetch.mask[i] = (PC_W'(i) >= slot_off);
        end
    end

endmodule
